// File: rtl/flex_counter_bank.sv
// Bank of independent flexible counters with programmable terminal, direction,
// wrap/saturate/one-shot modes, parallel load, and per-channel arrival flags.
module flex_counter_bank #(
    parameter int NUM_CH    = 4,
    parameter int CNT_BITS  = 8,
    parameter int START_VAL = 1
) (
    input  logic                         clk,
    input  logic                         n_rst,
    input  logic [NUM_CH-1:0]            clear,
    input  logic [NUM_CH-1:0]            load,
    input  logic [NUM_CH-1:0]            count_enable,
    input  logic [NUM_CH-1:0]            count_down,
    input  logic [2*NUM_CH-1:0]          mode,
    input  logic [NUM_CH*CNT_BITS-1:0]   load_val,
    input  logic [NUM_CH*CNT_BITS-1:0]   rollover_val,
    output logic [NUM_CH*CNT_BITS-1:0]   count_out,
    output logic [NUM_CH-1:0]            rollover_flag,
    output logic [NUM_CH-1:0]            rollover_pulse,
    output logic [NUM_CH-1:0]            done,
    output logic                         any_rollover
);

    localparam logic [CNT_BITS-1:0] START_V = CNT_BITS'(START_VAL);

    localparam logic [1:0] MODE_WRAP     = 2'b00;
    localparam logic [1:0] MODE_SATURATE = 2'b01;
    localparam logic [1:0] MODE_ONESHOT  = 2'b10;

    logic [NUM_CH-1:0] rise_s;
    logic              any_r;

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        logic [CNT_BITS-1:0] cnt_r;
        logic [CNT_BITS-1:0] next_cnt_s;
        logic [CNT_BITS-1:0] roll_s;
        logic [CNT_BITS-1:0] term_s;
        logic [1:0]          mode_s;
        logic                done_r;
        logic                next_done_s;
        logic                flag_r;
        logic                next_flag_s;
        logic                pulse_r;

        assign roll_s      = rollover_val[i*CNT_BITS +: CNT_BITS];
        assign mode_s      = mode[2*i +: 2];
        // Terminal follows the live direction input: counting down ends at START_VAL.
        assign term_s      = count_down[i] ? START_V : roll_s;
        assign next_flag_s = (next_cnt_s == term_s);
        assign rise_s[i]   = next_flag_s & ~flag_r;

        // Next count and done: clear > load > enable > hold.
        always_comb begin
            next_cnt_s  = cnt_r;
            next_done_s = done_r;
            if (clear[i]) begin
                next_cnt_s  = START_V;
                next_done_s = 1'b0;
            end else if (load[i]) begin
                next_cnt_s  = load_val[i*CNT_BITS +: CNT_BITS];
                next_done_s = 1'b0;
            end else if (count_enable[i]) begin
                if (done_r) begin
                    next_cnt_s = cnt_r;
                end else if (cnt_r != term_s) begin
                    next_cnt_s = count_down[i] ? (cnt_r - CNT_BITS'(1)) : (cnt_r + CNT_BITS'(1));
                end else begin
                    case (mode_s)
                        MODE_WRAP: next_cnt_s = count_down[i] ? roll_s : START_V;
                        MODE_SATURATE: next_cnt_s = cnt_r;
                        MODE_ONESHOT: begin
                            next_cnt_s  = cnt_r;
                            next_done_s = 1'b1;
                        end
                        default: next_cnt_s = count_down[i] ? roll_s : START_V;
                    endcase
                end
            end else begin
                next_cnt_s = cnt_r;
            end
        end

        // Per-channel state; flag and pulse register alongside the count update.
        always_ff @(posedge clk or negedge n_rst) begin
            if (!n_rst) begin
                cnt_r   <= {CNT_BITS{1'b0}};
                done_r  <= 1'b0;
                flag_r  <= 1'b0;
                pulse_r <= 1'b0;
            end else begin
                cnt_r   <= next_cnt_s;
                done_r  <= next_done_s;
                flag_r  <= next_flag_s;
                pulse_r <= rise_s[i];
            end
        end

        assign count_out[i*CNT_BITS +: CNT_BITS] = cnt_r;
        assign rollover_flag[i]                  = flag_r;
        assign rollover_pulse[i]                 = pulse_r;
        assign done[i]                           = done_r;
    end

    // Bank-wide arrival indicator, aligned with the per-channel pulses.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            any_r <= 1'b0;
        end else begin
            any_r <= |rise_s;
        end
    end

    assign any_rollover = any_r;

endmodule

// File: tb/tb_flex_counter_bank.sv
// Scoreboard bench for flex_counter_bank: expected per-channel states are queued
// as stimulus is applied and compared after each clock edge.
module tb_flex_counter_bank;
    localparam int NUM_CH   = 4;
    localparam int CNT_BITS = 8;

    logic                        clk = 1'b0;
    logic                        n_rst;
    logic [NUM_CH-1:0]           clear;
    logic [NUM_CH-1:0]           load;
    logic [NUM_CH-1:0]           count_enable;
    logic [NUM_CH-1:0]           count_down;
    logic [2*NUM_CH-1:0]         mode;
    logic [NUM_CH*CNT_BITS-1:0]  load_val;
    logic [NUM_CH*CNT_BITS-1:0]  rollover_val;
    logic [NUM_CH*CNT_BITS-1:0]  count_out;
    logic [NUM_CH-1:0]           rollover_flag;
    logic [NUM_CH-1:0]           rollover_pulse;
    logic [NUM_CH-1:0]           done;
    logic                        any_rollover;

    // Expected vector layout: {count, flag, pulse, done, any_rollover}
    typedef struct {
        int          ch;
        logic [11:0] v;
    } exp_t;

    exp_t sb_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    flex_counter_bank #(.NUM_CH(NUM_CH), .CNT_BITS(CNT_BITS), .START_VAL(1)) dut (
        .clk            (clk),
        .n_rst          (n_rst),
        .clear          (clear),
        .load           (load),
        .count_enable   (count_enable),
        .count_down     (count_down),
        .mode           (mode),
        .load_val       (load_val),
        .rollover_val   (rollover_val),
        .count_out      (count_out),
        .rollover_flag  (rollover_flag),
        .rollover_pulse (rollover_pulse),
        .done           (done),
        .any_rollover   (any_rollover)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit expired");
        $fatal(1, "watchdog");
    end

    function automatic logic [11:0] obs(int ch);
        return {count_out[ch*CNT_BITS +: CNT_BITS], rollover_flag[ch],
                rollover_pulse[ch], done[ch], any_rollover};
    endfunction

    task automatic push(int ch, logic [7:0] c, logic f, logic p, logic d, logic a);
        exp_t e;
        e.ch = ch;
        e.v  = {c, f, p, d, a};
        sb_q.push_back(e);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset_up_wrap();
        exp_t       e;
        logic [7:0] seq [11] = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd1};
        n_rst        = 1'b0;
        clear        = '0;
        load         = '0;
        count_enable = '0;
        count_down   = '0;
        mode         = '0;
        load_val     = '0;
        rollover_val = {8'd200, 8'd200, 8'd200, 8'd5};
        #12;
        for (int c = 0; c < NUM_CH; c++) push(c, 8'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        while (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            n_cmp++;
            if (obs(e.ch) !== e.v) begin
                n_bad++;
                $display("FAIL reset ch%0d got %h expected %h", e.ch, obs(e.ch), e.v);
            end
        end
        @(negedge clk);
        n_rst           = 1'b1;
        count_enable[0] = 1'b1;
        for (int i = 0; i < 11; i++) begin
            push(0, seq[i], seq[i] == 8'd5, seq[i] == 8'd5, 1'b0, seq[i] == 8'd5);
            tick();
            while (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                n_cmp++;
                if (obs(e.ch) !== e.v) begin
                    n_bad++;
                    $display("FAIL up_wrap step%0d ch%0d got %h expected %h", i, e.ch, obs(e.ch), e.v);
                end
            end
        end
        count_enable = '0;
    endtask

    task automatic test_down_wrap();
        exp_t       e;
        logic [7:0] seq [5] = '{8'd4, 8'd3, 8'd2, 8'd1, 8'd4};
        count_down[1]   = 1'b1;
        rollover_val[15:8] = 8'd4;
        clear[1]        = 1'b1;
        push(1, 8'd1, 1'b1, 1'b1, 1'b0, 1'b1);
        for (int i = 0; i < 6; i++) begin
            if (i > 0) push(1, seq[i-1], seq[i-1] == 8'd1, seq[i-1] == 8'd1, 1'b0, seq[i-1] == 8'd1);
            tick();
            clear[1]        = 1'b0;
            count_enable[1] = 1'b1;
            while (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                n_cmp++;
                if (obs(e.ch) !== e.v) begin
                    n_bad++;
                    $display("FAIL down_wrap step%0d ch%0d got %h expected %h", i, e.ch, obs(e.ch), e.v);
                end
            end
        end
        count_enable = '0;
    endtask

    task automatic test_saturate();
        exp_t       e;
        logic [7:0] seq [5] = '{8'd1, 8'd2, 8'd3, 8'd3, 8'd3};
        logic       pls [5] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        rollover_val[23:16] = 8'd3;
        mode[5:4]           = 2'b01;
        clear[2]            = 1'b1;
        for (int i = 0; i < 5; i++) begin
            push(2, seq[i], seq[i] == 8'd3, pls[i], 1'b0, pls[i]);
            tick();
            clear[2]        = 1'b0;
            count_enable[2] = 1'b1;
            while (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                n_cmp++;
                if (obs(e.ch) !== e.v) begin
                    n_bad++;
                    $display("FAIL saturate step%0d ch%0d got %h expected %h", i, e.ch, obs(e.ch), e.v);
                end
            end
        end
        count_enable = '0;
    endtask

    task automatic test_one_shot();
        exp_t e;
        rollover_val[31:24] = 8'd2;
        mode[7:6]           = 2'b10;
        clear[3]            = 1'b1;
        push(3, 8'd1, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 6; i++) begin
            case (i)
                1: push(3, 8'd2, 1'b1, 1'b1, 1'b0, 1'b1);
                2: push(3, 8'd2, 1'b1, 1'b0, 1'b1, 1'b0);
                3: push(3, 8'd2, 1'b1, 1'b0, 1'b1, 1'b0);
                4: push(3, 8'd7, 1'b0, 1'b0, 1'b0, 1'b0);
                5: push(3, 8'd8, 1'b0, 1'b0, 1'b0, 1'b0);
                default: ;
            endcase
            load[3]         = (i == 4);
            load_val[31:24] = 8'd7;
            tick();
            clear[3]        = 1'b0;
            count_enable[3] = 1'b1;
            while (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                n_cmp++;
                if (obs(e.ch) !== e.v) begin
                    n_bad++;
                    $display("FAIL one_shot step%0d ch%0d got %h expected %h", i, e.ch, obs(e.ch), e.v);
                end
            end
        end
        load         = '0;
        count_enable = '0;
    endtask

    task automatic test_priority_boundaries();
        exp_t e;
        for (int i = 0; i < 5; i++) begin
            clear = '0;
            load  = '0;
            count_enable = '0;
            case (i)
                0: begin
                    clear[0] = 1'b1; load[0] = 1'b1; count_enable[0] = 1'b1;
                    load_val[7:0] = 8'd9;
                    count_enable[2] = 1'b1; count_enable[3] = 1'b1;
                    push(0, 8'd1, 1'b0, 1'b0, 1'b0, 1'b0);
                    push(2, 8'd3, 1'b1, 1'b0, 1'b0, 1'b0);
                    push(3, 8'd9, 1'b0, 1'b0, 1'b0, 1'b0);
                end
                1: begin
                    load[0] = 1'b1; load_val[7:0] = 8'd5;
                    push(0, 8'd5, 1'b1, 1'b1, 1'b0, 1'b1);
                end
                2: begin
                    load[0] = 1'b1;
                    push(0, 8'd5, 1'b1, 1'b0, 1'b0, 1'b0);
                end
                3: begin
                    load[1] = 1'b1; load_val[15:8] = 8'd0;
                    push(1, 8'd0, 1'b0, 1'b0, 1'b0, 1'b0);
                end
                4: begin
                    count_enable[1] = 1'b1;
                    push(1, 8'd255, 1'b0, 1'b0, 1'b0, 1'b0);
                end
                default: ;
            endcase
            tick();
            while (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                n_cmp++;
                if (obs(e.ch) !== e.v) begin
                    n_bad++;
                    $display("FAIL priority step%0d ch%0d got %h expected %h", i, e.ch, obs(e.ch), e.v);
                end
            end
        end
        clear = '0;
        load  = '0;
        count_enable = '0;
    endtask

    task automatic test_async_reset();
        exp_t e;
        clear[3]     = 1'b1;
        count_enable = '1;
        tick();
        clear[3] = 1'b0;
        tick();
        tick();
        push(3, 8'd2, 1'b1, 1'b0, 1'b1, 1'b0);
        push(0, 8'd3, 1'b0, 1'b0, 1'b0, 1'b0);
        push(1, 8'd252, 1'b0, 1'b0, 1'b0, 1'b0);
        while (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            n_cmp++;
            if (obs(e.ch) !== e.v) begin
                n_bad++;
                $display("FAIL pre_reset ch%0d got %h expected %h", e.ch, obs(e.ch), e.v);
            end
        end
        #2;
        n_rst = 1'b0;
        #1;
        for (int c = 0; c < NUM_CH; c++) push(c, 8'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        for (int c = 0; c < NUM_CH; c++) push(c, 8'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        while (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            n_cmp++;
            if (obs(e.ch) !== e.v) begin
                n_bad++;
                $display("FAIL async_reset ch%0d got %h expected %h", e.ch, obs(e.ch), e.v);
            end
        end
        count_enable = '0;
        @(negedge clk);
        n_rst = 1'b1;
    endtask

    initial begin
        test_reset_up_wrap();
        test_down_wrap();
        test_saturate();
        test_one_shot();
        test_priority_boundaries();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
